wishbone_line_arbiter: RTL and testbench
========================================

Name: wishbone_line_arbiter

Overview:
- Parametrised N-master to 1-slave Wishbone (classic, single-beat) arbiter for line-wide memory ports.
- Merges the CPU's per-stage masters (instruction fetch, data memory, and later prefetch or DMA channels) onto one shared physical memory/cache port.
- Arbitration is round-robin with registered grant, transaction abort and a no-ACK watchdog that returns ERR to the stalled master.

Parameters:
- N_MASTERS, 2, number of master channels (≥2); index 0 is the highest priority after reset.
- ADDR_W, 16, address width.
- LINE_W, 128, data line width in bits; must be a multiple of 8.
- SEL_W, LINE_W/8, byte-select width (derived; not overridden).
- TIMEOUT, 255, cycles in BUSY without ACK before ERR; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_cyc  in  N_MASTERS  per-master CYC.
- m_stb  in  N_MASTERS  per-master STB.
- m_we  in  N_MASTERS  per-master write enable.
- m_adr  in  N_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W].
- m_sel  in  N_MASTERS*SEL_W  packed byte selects.
- m_dat_m  in  N_MASTERS*LINE_W  packed write data.
- m_dat_s  out  LINE_W  read data, broadcast to all masters.
- m_ack  out  N_MASTERS  per-master ACK; one-hot or zero.
- m_err  out  N_MASTERS  per-master timeout error; one-hot or zero.
- s_cyc  out  1  slave CYC.
- s_stb  out  1  slave STB.
- s_we  out  1  slave write enable.
- s_adr  out  ADDR_W  slave address.
- s_sel  out  SEL_W  slave byte select.
- s_dat_m  out  LINE_W  slave write data.
- s_dat_s  in  LINE_W  slave read data.
- s_ack  in  1  slave ACK.
- grant  out  $clog2(N_MASTERS)  current owner; valid while busy.
- busy  out  1  high in BUSY.

Behaviour:
- **Reset (rst_n low, asynchronous):**
  - State goes to IDLE; last_grant = N_MASTERS-1; mask = 0; timer = 0.
  - All outputs 0, including s_cyc and s_stb, immediately and without waiting for clk.
  - Reset mid-transaction drops the slave cycle; no ACK or ERR is issued.
- **Request:** master i requests when m_cyc[i] & m_stb[i] & ~mask[i].
- **IDLE:**
  - If any request exists, pick the first requester scanning from last_grant+1 upward with modulo N_MASTERS wrap.
  - Register it into grant and go to BUSY.
  - No request: stay in IDLE.
  - Slave outputs are 0 while IDLE.
- **BUSY:**
  - s_cyc, s_stb, s_we, s_adr, s_sel and s_dat_m are combinationally muxed from master[grant].
  - m_ack[grant] = s_ack; m_dat_s = s_dat_s always.
  - Requests from other masters are ignored (no preemption).
- **Completion:**
  - On s_ack in BUSY, go to IDLE; last_grant = grant; mask = one-hot(grant) for exactly one cycle.
  - The mask means a master that has not yet dropped CYC after ACK is not re-issued.
  - A master that still requests in the following IDLE cycle is seen again one cycle later.
- **Abort:** if m_cyc[grant] is low in BUSY, go to IDLE the next cycle with no ACK; last_grant = grant.
  - s_cyc already follows the master low in that cycle.
  - A late s_ack in the same cycle is still forwarded to m_ack[grant].
- **Watchdog:**
  - timer clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When timer == TIMEOUT-1 and s_ack is low: m_err[grant] pulses for one cycle; in that cycle s_cyc and s_stb are forced to 0.
  - State then goes to IDLE; last_grant = grant; mask is set as on ACK.
  - s_ack arriving in the same cycle as expiry wins: ACK is given, no ERR.
- **Latency:**
  - Request seen at edge k (IDLE) → s_cyc high at cycle k+1.
  - Zero-wait slave ACK in that cycle → 2-cycle access.
  - Minimum spacing between back-to-back grants is one IDLE cycle.
- **Invariants:** m_ack and m_err are never both high, and never high for a non-granted master.

Test Plan:
- **Single request:** N=2; master 0 reads adr 0x1230, sel 0xFFFF; slave ACKs on its first cycle with data 0xDEAD...BEEF → s_cyc is high 1 cycle after the request; m_ack[0] is high in the same cycle as s_ack; m_dat_s matches; m_ack[1] stays 0.
- **Round-robin:** both masters request continuously; slave ACKs immediately → grant sequence 0,1,0,1; each grant is separated by exactly one busy=0 cycle; m_ack alternates.
- **Post-ACK mask:** master 1 holds CYC/STB one extra cycle after its ACK while master 0 is idle → no second slave cycle to master 1 in the cycle after ACK; if it still requests, it is granted the cycle after that.
- **Abort:** master 0 granted, drops m_cyc after 2 cycles with no s_ack → s_cyc low in that cycle; no m_ack/m_err; busy=0 next cycle; pending master 1 is granted next.
- **Timeout:** TIMEOUT=4; slave never ACKs → m_err[grant] pulses in the 4th BUSY cycle with s_cyc=0; back to IDLE. Repeat with s_ack in exactly that cycle → m_ack, no m_err.
- **Async reset mid-write:** assert rst_n low between clock edges while BUSY on a write → s_cyc, s_we, busy and grant go to 0 before the next edge. After release, simultaneous requests from both masters grant master 0 first.

Source files
------------

// File: rtl/wishbone_line_arbiter.sv
// rtl/wishbone_line_arbiter.sv - round-robin N:1 Wishbone line arbiter with abort and no-ACK watchdog
module wishbone_line_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 16,
  parameter int LINE_W    = 128,
  parameter int TIMEOUT   = 255,
  localparam int SEL_W    = LINE_W / 8,
  localparam int GW       = $clog2(N_MASTERS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_MASTERS-1:0]        m_cyc,
  input  logic [N_MASTERS-1:0]        m_stb,
  input  logic [N_MASTERS-1:0]        m_we,
  input  logic [N_MASTERS*ADDR_W-1:0] m_adr,
  input  logic [N_MASTERS*SEL_W-1:0]  m_sel,
  input  logic [N_MASTERS*LINE_W-1:0] m_dat_m,
  output logic [LINE_W-1:0]           m_dat_s,
  output logic [N_MASTERS-1:0]        m_ack,
  output logic [N_MASTERS-1:0]        m_err,
  output logic                        s_cyc,
  output logic                        s_stb,
  output logic                        s_we,
  output logic [ADDR_W-1:0]           s_adr,
  output logic [SEL_W-1:0]            s_sel,
  output logic [LINE_W-1:0]           s_dat_m,
  input  logic [LINE_W-1:0]           s_dat_s,
  input  logic                        s_ack,
  output logic [GW-1:0]               grant,
  output logic                        busy
);

  // Timer only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WDOG_EN = (TIMEOUT > 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic [GW-1:0]        grant_nxt;
  logic [GW-1:0]        last_grant, last_grant_nxt;
  logic [N_MASTERS-1:0] mask, mask_nxt;
  logic [TW-1:0]        timer, timer_nxt;
  logic [N_MASTERS-1:0] req;
  logic                 pick_valid;
  logic [GW-1:0]        pick_idx;
  logic                 own_cyc;
  logic                 expire;

  // A master that was just served is hidden for one cycle so a lingering CYC is not re-issued.
  assign req     = m_cyc & m_stb & ~mask;
  assign busy    = (state == BUSY);
  assign own_cyc = m_cyc[grant];
  assign expire  = WDOG_EN && busy && own_cyc && !s_ack && (timer == T_LAST);
  assign m_dat_s = s_dat_s;

  // Round-robin pick: first requester after last_grant, wrapping modulo N_MASTERS.
  always_comb begin
    int cand;
    cand       = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = (int'(last_grant) + k) % N_MASTERS;
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = GW'(cand);
      end
    end
  end

  // Slave side follows the owner while BUSY; watchdog expiry forces the bus cycle off.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_sel   = '0;
    s_dat_m = '0;
    m_ack   = '0;
    m_err   = '0;
    if (state == BUSY) begin
      s_cyc        = m_cyc[grant] & ~expire;
      s_stb        = m_stb[grant] & ~expire;
      s_we         = m_we[grant];
      s_adr        = m_adr[int'(grant)*ADDR_W +: ADDR_W];
      s_sel        = m_sel[int'(grant)*SEL_W +: SEL_W];
      s_dat_m      = m_dat_m[int'(grant)*LINE_W +: LINE_W];
      m_ack[grant] = s_ack;
      m_err[grant] = expire;
    end
  end

  // Next-state: grant on request, finish on ACK, abort on dropped CYC, or time out.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    mask_nxt       = '0;
    timer_nxt      = timer;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nxt = BUSY;
          grant_nxt = pick_idx;
          timer_nxt = '0;
        end
      end
      BUSY: begin
        if (s_ack) begin
          state_nxt       = IDLE;
          last_grant_nxt  = grant;
          mask_nxt[grant] = 1'b1;
        end else if (!own_cyc) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end else if (expire) begin
          state_nxt       = IDLE;
          last_grant_nxt  = grant;
          mask_nxt[grant] = 1'b1;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset parks last_grant at the top so master 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N_MASTERS - 1);
      mask       <= '0;
      timer      <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      mask       <= mask_nxt;
      timer      <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_wishbone_line_arbiter.sv
// tb/tb_wishbone_line_arbiter.sv - scoreboard bench for wishbone_line_arbiter
module tb_wishbone_line_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   m_cyc, m_stb, m_we;
  logic [31:0]  m_adr;
  logic [31:0]  m_sel;
  logic [255:0] m_dat_m;
  logic [127:0] m_dat_s;
  logic [1:0]   m_ack, m_err;
  logic         s_cyc, s_stb, s_we;
  logic [15:0]  s_adr;
  logic [15:0]  s_sel;
  logic [127:0] s_dat_m;
  logic [127:0] s_dat_s;
  logic         s_ack;
  logic [0:0]   grant;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;
  int slave_w = 1;
  int slave_cnt = 0;

  typedef struct {
    int          master;
    bit          err;
    logic [15:0] adr;
    bit          we;
  } sb_t;
  sb_t sb_q[$];

  wishbone_line_arbiter #(
    .N_MASTERS(2), .ADDR_W(16), .LINE_W(128), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_m(m_dat_m), .m_dat_s(m_dat_s), .m_ack(m_ack), .m_err(m_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_m(s_dat_m), .s_dat_s(s_dat_s), .s_ack(s_ack),
    .grant(grant), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] data_for(input logic [15:0] a);
    return {16'hDEAD, a, 64'h0123_4567_89AB_CDEF, ~a, 16'hBEEF};
  endfunction

  function automatic logic [127:0] line_for(input int i, input logic [15:0] a);
    return {8{a ^ 16'(i + 1)}};
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input bit req, input bit we, input logic [15:0] adr,
                       input logic [15:0] sel);
    m_cyc[i]              = req;
    m_stb[i]              = req;
    m_we[i]               = we;
    m_adr[i*16 +: 16]     = adr;
    m_sel[i*16 +: 16]     = sel;
    m_dat_m[i*128 +: 128] = line_for(i, adr);
  endtask

  task automatic sb_push(input int master, input bit err, input logic [15:0] adr, input bit we);
    sb_t e;
    e.master = master;
    e.err    = err;
    e.adr    = adr;
    e.we     = we;
    sb_q.push_back(e);
  endtask

  // Slave model: ACKs on the slave_w-th consecutive BUSY cycle (0 = never), data keyed by address.
  initial begin
    s_ack   = 1'b0;
    s_dat_s = '0;
    forever begin
      @(posedge clk);
      #2;
      if (busy === 1'b1) slave_cnt++;
      else slave_cnt = 0;
      s_ack   = (slave_w != 0) && (busy === 1'b1) && (slave_cnt == slave_w);
      s_dat_s = data_for(s_adr);
    end
  end

  // Scoreboard monitor: every ACK/ERR must match the oldest expected completion.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (m_ack != 0 || m_err != 0)) begin
        check_eq("sb_ack_err_excl", m_ack & m_err, 0);
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", {m_err, m_ack}, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_kind", m_err != 0, e.err);
          check_eq("sb_master", m_ack | m_err, 2'b01 << e.master);
          check_eq("sb_adr", s_adr, e.adr);
          check_eq("sb_we", s_we, e.we);
          if (!e.err) check_eq("sb_rdata", m_dat_s, data_for(e.adr));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_sel = '0; m_dat_m = '0;
    smp();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_s_cyc", s_cyc, 0);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_ack", {m_err, m_ack}, 0);
    drv(); rst_n = 1'b1;

    // Single request from master 0, zero-wait slave
    slave_w = 1;
    drv(); set_m(0, 1, 0, 16'h1230, 16'hFFFF); sb_push(0, 0, 16'h1230, 0);
    smp(); check_eq("t1_idle_s_cyc", s_cyc, 0);
    drv(); smp();
    check_eq("t1_s_cyc", s_cyc, 1);
    check_eq("t1_ack", m_ack, 2'b01);
    check_eq("t1_rdata", m_dat_s, data_for(16'h1230));
    drv(); set_m(0, 0, 0, 16'h0, 16'h0);
    smp(); check_eq("t1_done_busy", busy, 0);

    // Round-robin from reset: 0,1,0,1 with an IDLE cycle between grants
    drv(); rst_n = 1'b0;
    drv(); rst_n = 1'b1;
    drv();
    set_m(0, 1, 0, 16'h0100, 16'hFFFF);
    set_m(1, 1, 0, 16'h0200, 16'hFFFF);
    sb_push(0, 0, 16'h0100, 0); sb_push(1, 0, 16'h0200, 0);
    sb_push(0, 0, 16'h0100, 0); sb_push(1, 0, 16'h0200, 0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) drv();
      smp();
      check_eq($sformatf("rr_busy%0d", c), busy, c % 2);
      if (c % 2 == 1) begin
        check_eq($sformatf("rr_grant%0d", c), grant, (c / 2) % 2);
        check_eq($sformatf("rr_ack%0d", c), m_ack, 2'b01 << ((c / 2) % 2));
      end
    end
    drv(); set_m(0, 0, 0, 16'h0, 16'h0); set_m(1, 0, 0, 16'h0, 16'h0);
    smp(); check_eq("rr_done_busy", busy, 0);

    // Post-ACK mask: master 1 keeps CYC after its ACK
    drv(); set_m(1, 1, 0, 16'h0300, 16'hFFFF);
    sb_push(1, 0, 16'h0300, 0); sb_push(1, 0, 16'h0300, 0);
    smp(); check_eq("mask_idle0", busy, 0);
    drv(); smp();
    check_eq("mask_grant", grant, 1);
    check_eq("mask_ack", m_ack, 2'b10);
    drv(); smp();
    check_eq("mask_blocked_busy", busy, 0);
    check_eq("mask_blocked_s_cyc", s_cyc, 0);
    drv(); smp(); check_eq("mask_seen_idle", busy, 0);
    drv(); smp();
    check_eq("mask_regrant_busy", busy, 1);
    check_eq("mask_regrant_ack", m_ack, 2'b10);
    drv(); set_m(1, 0, 0, 16'h0, 16'h0);
    smp(); check_eq("mask_done_busy", busy, 0);

    // Abort by master 0 with master 1 pending, then master 1 times out
    slave_w = 0;
    drv();
    set_m(0, 1, 0, 16'h0400, 16'hFFFF);
    set_m(1, 1, 0, 16'h0500, 16'hFFFF);
    sb_push(1, 1, 16'h0500, 0);
    smp(); check_eq("ab_idle", busy, 0);
    drv(); smp();
    check_eq("ab_grant0", grant, 0);
    check_eq("ab_s_cyc1", s_cyc, 1);
    drv(); smp(); check_eq("ab_s_cyc2", s_cyc, 1);
    drv(); set_m(0, 0, 0, 16'h0400, 16'hFFFF);
    smp();
    check_eq("ab_drop_s_cyc", s_cyc, 0);
    check_eq("ab_drop_ackerr", {m_err, m_ack}, 0);
    drv(); smp(); check_eq("ab_after_busy", busy, 0);
    drv(); smp();
    check_eq("ab_next_busy", busy, 1);
    check_eq("ab_next_grant", grant, 1);
    drv(); smp(); check_eq("to_no_err1", m_err, 0);
    drv(); smp(); check_eq("to_no_err2", m_err, 0);
    drv(); smp();
    check_eq("to_err", m_err, 2'b10);
    check_eq("to_s_cyc", s_cyc, 0);
    check_eq("to_s_stb", s_stb, 0);
    drv(); set_m(1, 0, 0, 16'h0, 16'h0);
    smp(); check_eq("to_idle", busy, 0);

    // ACK exactly at watchdog expiry wins
    slave_w = 4;
    drv(); set_m(0, 1, 0, 16'h0600, 16'hFFFF); sb_push(0, 0, 16'h0600, 0);
    smp();
    for (int c = 1; c <= 3; c++) begin
      drv(); smp();
      check_eq($sformatf("ae_wait%0d", c), {m_err, m_ack}, 0);
    end
    drv(); smp();
    check_eq("ae_ack", m_ack, 2'b01);
    check_eq("ae_no_err", m_err, 0);
    check_eq("ae_s_cyc", s_cyc, 1);
    drv(); set_m(0, 0, 0, 16'h0, 16'h0);
    smp(); check_eq("ae_idle", busy, 0);

    // Asynchronous reset in the middle of a master-1 write
    slave_w = 0;
    drv(); set_m(1, 1, 1, 16'h0BEE, 16'h00F0);
    smp();
    drv(); smp();
    check_eq("rw_grant", grant, 1);
    check_eq("rw_s_we", s_we, 1);
    check_eq("rw_s_sel", s_sel, 16'h00F0);
    check_eq("rw_s_dat_m", s_dat_m, line_for(1, 16'h0BEE));
    #2; rst_n = 1'b0;
    #1;
    check_eq("rw_rst_s_cyc", s_cyc, 0);
    check_eq("rw_rst_s_we", s_we, 0);
    check_eq("rw_rst_busy", busy, 0);
    check_eq("rw_rst_grant", grant, 0);
    drv(); rst_n = 1'b1; slave_w = 1;
    set_m(0, 1, 0, 16'h0700, 16'hFFFF); sb_push(0, 0, 16'h0700, 0);
    smp(); check_eq("rw_post_idle", busy, 0);
    drv(); smp();
    check_eq("rw_post_grant", grant, 0);
    check_eq("rw_post_ack", m_ack, 2'b01);
    drv(); set_m(0, 0, 0, 16'h0, 16'h0); set_m(1, 0, 0, 16'h0, 16'h0);
    smp(); check_eq("rw_post_done", busy, 0);

    drv();
    check_eq("sb_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
